sum_accumulator_4b: RTL and testbench



---
 rtl/sum_accumulator_4b.sv | 98 +++++++++
 tb/tb_sum_accumulator_4b.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator_4b.sv
// sum_accumulator_4b
// Sums N_OPERANDS results from the 4-bit full adder ({cout, sum}, 0..31)
// into an ACC_W-bit running total. Overflow is sticky for the run. The
// finished total is offered under a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      begin a new run (IDLE only)
//   in_valid   operand on sum/cout is valid
//   in_ready   operand accepted this cycle (ACCUM state)
//   sum        adder sum bits
//   cout       adder carry-out, weight 16
//   out_valid  total/overflow/count are final (DONE state)
//   out_ready  consumer takes the result
//   total      accumulated value modulo 2^ACC_W
//   overflow   sticky carry out of the accumulator
//   count      operands accepted in the current run
module sum_accumulator_4b #(
  parameter int N_OPERANDS = 4,
  parameter int ACC_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sum,
  input  logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] total,
  output logic             overflow,
  output logic [3:0]       count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  logic [ACC_W:0] operand;
  logic [ACC_W:0] next_sum;
  logic           accept;
  logic           last_accept;

  // Handshake outputs come from the registered state only.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);

  assign accept      = in_valid && in_ready;
  assign last_accept = (count == 4'(N_OPERANDS - 1));

  always_comb begin
    operand  = '0;
    operand  = {{(ACC_W - 4){1'b0}}, cout, sum};
    next_sum = {1'b0, total} + operand;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      total    <= '0;
      overflow <= 1'b0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            total    <= '0;
            overflow <= 1'b0;
            count    <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            total    <= next_sum[ACC_W-1:0];
            overflow <= overflow | next_sum[ACC_W];
            count    <= count + 4'd1;
            if (last_accept) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator_4b.sv
module tb_sum_accumulator_4b;

  typedef struct packed {
    logic [7:0] t;
    logic       o;
    logic [3:0] c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] sum = '0;
  logic       cout = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready_a, out_valid_a, overflow_a;
  logic [7:0] total_a;
  logic [3:0] count_a;
  logic       in_ready_b, out_valid_b, overflow_b;
  logic [5:0] total_b;
  logic [3:0] count_b;

  int tests = 0;
  int fails = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  sum_accumulator_4b #(.N_OPERANDS(4), .ACC_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid),
    .in_ready(in_ready_a), .sum(sum), .cout(cout), .out_valid(out_valid_a),
    .out_ready(out_ready), .total(total_a), .overflow(overflow_a), .count(count_a)
  );

  sum_accumulator_4b #(.N_OPERANDS(4), .ACC_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid),
    .in_ready(in_ready_b), .sum(sum), .cout(cout), .out_valid(out_valid_b),
    .out_ready(out_ready), .total(total_b), .overflow(overflow_b), .count(count_b)
  );

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Monitors: compare whenever a result is handed over.
  always @(negedge clk) begin
    if (out_valid_a === 1'b1 && out_ready === 1'b1) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_total", int'(total_a), int'(e.t));
        chk("a_overflow", int'(overflow_a), int'(e.o));
        chk("a_count", int'(count_a), int'(e.c));
      end
    end
    if (out_valid_b === 1'b1 && out_ready === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_total", int'(total_b), int'(e.t));
        chk("b_overflow", int'(overflow_b), int'(e.o));
        chk("b_count", int'(count_b), int'(e.c));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit which_b);
    if (which_b) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic feed(input logic [4:0] v);
    in_valid = 1'b1;
    {cout, sum} = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handshake(input bit which_b);
    int n = 0;
    while (((which_b ? out_valid_b : out_valid_a) !== 1'b1) && n < 20) begin
      tick();
      n++;
    end
    if ((which_b ? out_valid_b : out_valid_a) !== 1'b1) begin
      chk("out_valid_timeout", 0, 1);
    end else begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("out_valid_drop", int'(which_b ? out_valid_b : out_valid_a), 0);
    end
  endtask

  initial begin
    // Reset and idle behaviour
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_total", int'(total_a), 0);
    chk("rst_overflow", int'(overflow_a), 0);
    chk("rst_count", int'(count_a), 0);
    chk("rst_in_ready", int'(in_ready_a), 0);
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk("rst_b_in_ready", int'(in_ready_b), 0);
    feed(5'd7);
    chk("idle_ignore_total", int'(total_a), 0);
    chk("idle_ignore_count", int'(count_a), 0);
    chk("idle_in_ready", int'(in_ready_a), 0);

    // Basic run: 0+1+4+5 = 10
    qa.push_back('{t: 8'd10, o: 1'b0, c: 4'd4});
    pulse_start(1'b0);
    chk("start_in_ready", int'(in_ready_a), 1);
    feed(5'd0); feed(5'd1); feed(5'd4); feed(5'd5);
    chk("basic_out_valid_latency", int'(out_valid_a), 1);
    chk("done_in_ready", int'(in_ready_a), 0);
    handshake(1'b0);

    // Carry weighting: 12+14+15+16 = 57, held while out_ready is low
    qa.push_back('{t: 8'd57, o: 1'b0, c: 4'd4});
    pulse_start(1'b0);
    feed(5'd12); feed(5'd14); feed(5'd15); feed(5'd16);
    for (int unsigned i = 0; i < 3; i++) begin
      chk("hold_total", int'(total_a), 57);
      chk("hold_out_valid", int'(out_valid_a), 1);
      tick();
    end
    handshake(1'b0);
    chk("idle_keeps_total", int'(total_a), 57);

    // Overflow with ACC_W=6: 4*31 = 124 -> 60 mod 64
    qb.push_back('{t: 8'd60, o: 1'b1, c: 4'd4});
    pulse_start(1'b1);
    for (int unsigned i = 0; i < 4; i++) feed(5'd31);
    handshake(1'b1);

    // Stalls and an ignored start: 1+2+3+9 = 15
    qa.push_back('{t: 8'd15, o: 1'b0, c: 4'd4});
    pulse_start(1'b0);
    feed(5'd1);
    tick();
    tick();
    chk("stall_count", int'(count_a), 1);
    start_a = 1'b1;
    feed(5'd2);
    start_a = 1'b0;
    tick();
    feed(5'd3);
    chk("mid_start_count", int'(count_a), 3);
    chk("mid_start_total", int'(total_a), 6);
    feed(5'd9);
    feed(5'd7);
    chk("done_ignore_total", int'(total_a), 15);
    chk("done_ignore_count", int'(count_a), 4);
    handshake(1'b0);

    // Reset mid-run discards partial result
    pulse_start(1'b0);
    feed(5'd1); feed(5'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_total", int'(total_a), 0);
    chk("midrst_count", int'(count_a), 0);
    chk("midrst_in_ready", int'(in_ready_a), 0);
    qa.push_back('{t: 8'd4, o: 1'b0, c: 4'd4});
    pulse_start(1'b0);
    for (int unsigned i = 0; i < 4; i++) feed(5'd1);
    handshake(1'b0);

    tick();
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
